fifo_axis_reader: RTL and testbench

FIFO_AXIS_READER -- requirements
Module: fifo_axis_reader

---
 rtl/fifo_axis_reader_pkg.sv | 14 +
 rtl/fifo_axis_reader.sv | 106 ++++++++++
 tb/tb_fifo_axis_reader.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_axis_reader_pkg.sv
// Shared stream package: reader FSM state encodings and common widths.
// Imported by the FIFO-to-AXI-Stream reader.
package fifo_axis_reader_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        FIN    = 2'd3
    } state_t;

endpackage

// File: rtl/fifo_axis_reader.sv
// Pops a fixed number of words from a show-ahead FIFO and presents them
// as an AXI-Stream transfer through a single output register stage.
module fifo_axis_reader
    import fifo_axis_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    input  logic                  fifo_rempty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_re,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast
);

    state_t               state;
    state_t               state_nxt;
    logic [LEN_WIDTH-1:0] remaining;
    logic                 pop;
    logic                 accept;
    logic                 last_word;

    assign accept    = m_axis_tvalid & m_axis_tready;
    assign last_word = (remaining == LEN_WIDTH'(1));

    // Next-state and pop decision; a pop only happens when the output
    // register is empty or being emptied this cycle.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? FIN : STREAM;
                end
            end
            STREAM: begin
                pop = !fifo_rempty && (remaining != '0) &&
                      (!m_axis_tvalid || m_axis_tready);
                if (pop && last_word) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (accept && m_axis_tlast) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign fifo_re = pop;
    assign busy    = (state != IDLE);
    assign done    = (state == FIN);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Beat counter: loaded when a transfer is accepted, counts pops down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
        end else if (state == IDLE && start) begin
            remaining <= len;
        end else if (pop) begin
            remaining <= remaining - LEN_WIDTH'(1);
        end
    end

    // Output register: load on pop, empty on accept, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (pop) begin
            m_axis_tdata  <= fifo_rdata;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= last_word;
        end else if (accept) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Directed bench for fifo_axis_reader with a behavioural show-ahead FIFO
// and a per-cycle stream monitor; each scenario checks its own results.
module tb_fifo_axis_reader;

    localparam int DW = 8;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          busy;
    logic          done;
    logic          fifo_rempty;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_re;
    logic          tvalid;
    logic          tready = 1'b0;
    logic [DW-1:0] tdata;
    logic          tlast;

    // Behavioural FIFO: pointers never reset, so DUT reset leaves it untouched.
    logic [DW-1:0] mem [0:2047];
    logic [11:0]   rd_ptr = '0;
    logic [11:0]   wr_ptr = '0;

    assign fifo_rempty = (rd_ptr == wr_ptr);
    assign fifo_rdata  = mem[rd_ptr[10:0]];

    always @(posedge clk) begin
        if (fifo_re) rd_ptr <= rd_ptr + 12'd1;
    end

    always #5 clk = ~clk;

    fifo_axis_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .len           (len),
        .busy          (busy),
        .done          (done),
        .fifo_rempty   (fifo_rempty),
        .fifo_rdata    (fifo_rdata),
        .fifo_re       (fifo_re),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tdata  (tdata),
        .m_axis_tlast  (tlast)
    );

    int checks = 0;
    int failures = 0;

    int            nbeats, ndone, done_cyc, re_seen, tv_seen;
    int            stall_viol, gap_seen;
    logic          done_busy;
    logic [DW-1:0] bd [0:2047];
    logic          bl [0:2047];
    int            bc [0:2047];
    int            ready_mode = 0;
    int            refill_at = -1;
    int            restart_at = -1;
    logic [DW-1:0] refill_q [$];

    task automatic push(input logic [DW-1:0] d);
        mem[wr_ptr[10:0]] = d;
        wr_ptr = wr_ptr + 12'd1;
    endtask

    // Runs cycles from the negedge after start, recording stream activity.
    task automatic run(input int max_cyc);
        logic          pv, pr, pl;
        logic [DW-1:0] pd;
        pv = 0; pr = 0; pl = 0; pd = '0;
        nbeats = 0; ndone = 0; done_cyc = -1; re_seen = 0; tv_seen = 0;
        stall_viol = 0; gap_seen = 0; done_busy = 0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            start = (c == restart_at);
            if (c == restart_at) len = 10'd9;
            if (c == refill_at) begin
                foreach (refill_q[i]) push(refill_q[i]);
            end
            tready = (ready_mode == 0) ? 1'b1 : (c % 3 == 0);
            #1;
            if (pv && !pr && (!tvalid || tdata !== pd || tlast !== pl))
                stall_viol++;
            if (tvalid && tready) begin
                bd[nbeats] = tdata;
                bl[nbeats] = tlast;
                bc[nbeats] = c;
                nbeats++;
            end
            if (done) begin
                if (ndone == 0) begin
                    done_cyc  = c;
                    done_busy = busy;
                end
                ndone++;
            end
            if (fifo_re) re_seen++;
            if (tvalid) tv_seen++;
            if (busy && !tvalid && !done && nbeats > 0) gap_seen++;
            pv = tvalid; pr = tready; pd = tdata; pl = tlast;
            if (ndone > 0 && c >= done_cyc + 2) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({busy, done, tvalid, tlast, fifo_re} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctl got=%b want=00000",
                     {busy, done, tvalid, tlast, fifo_re});
        end
        checks++;
        if (tdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_tdata got=%0h want=0", tdata);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_basic();
        logic [DW-1:0] exp [4];
        exp = '{8'h11, 8'h22, 8'h33, 8'h44};
        foreach (exp[i]) push(exp[i]);
        ready_mode = 0;
        start = 1'b1; len = 10'd4;
        run(20);
        checks++;
        if (nbeats !== 4) begin
            failures++;
            $display("FAIL basic_beats got=%0d want=4", nbeats);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bd[i] !== exp[i] || bl[i] !== (i == 3)) begin
                failures++;
                $display("FAIL basic_beat%0d got=%0h/%b want=%0h/%b",
                         i, bd[i], bl[i], exp[i], (i == 3));
            end
        end
        checks++;
        if (bc[3] - bc[0] !== 3) begin
            failures++;
            $display("FAIL basic_b2b got=%0d want=3", bc[3] - bc[0]);
        end
        checks++;
        if (ndone !== 1 || done_cyc !== bc[3] + 1 || done_busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_done got=%0d@%0d busy=%b want=1@%0d busy=1",
                     ndone, done_cyc, done_busy, bc[3] + 1);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle got=%b want=0", busy);
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] exp [3];
        exp = '{8'hA0, 8'hA1, 8'hA2};
        foreach (exp[i]) push(exp[i]);
        ready_mode = 1;
        start = 1'b1; len = 10'd3;
        run(40);
        checks++;
        if (stall_viol !== 0) begin
            failures++;
            $display("FAIL stall_stable got=%0d want=0", stall_viol);
        end
        checks++;
        if (nbeats !== 3 || ndone !== 1) begin
            failures++;
            $display("FAIL stall_count got=%0d/%0d want=3/1", nbeats, ndone);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bd[i] !== exp[i] || bl[i] !== (i == 2)) begin
                failures++;
                $display("FAIL stall_beat%0d got=%0h/%b want=%0h/%b",
                         i, bd[i], bl[i], exp[i], (i == 2));
            end
        end
        ready_mode = 0;
    endtask

    task automatic test_gap();
        push(8'h60);
        push(8'h61);
        refill_q = '{8'h62, 8'h63, 8'h64, 8'h65};
        refill_at = 5;
        start = 1'b1; len = 10'd6;
        run(40);
        refill_at = -1;
        checks++;
        if (gap_seen == 0) begin
            failures++;
            $display("FAIL gap_tvalid got=%0d want>0", gap_seen);
        end
        checks++;
        if (nbeats !== 6 || ndone !== 1) begin
            failures++;
            $display("FAIL gap_count got=%0d/%0d want=6/1", nbeats, ndone);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (bd[i] !== 8'(8'h60 + i) || bl[i] !== (i == 5)) begin
                failures++;
                $display("FAIL gap_beat%0d got=%0h/%b want=%0h/%b",
                         i, bd[i], bl[i], 8'(8'h60 + i), (i == 5));
            end
        end
    endtask

    task automatic test_len_zero();
        start = 1'b1; len = 10'd0;
        run(10);
        checks++;
        if (ndone !== 1 || done_cyc !== 0) begin
            failures++;
            $display("FAIL len0_done got=%0d@%0d want=1@0", ndone, done_cyc);
        end
        checks++;
        if (re_seen !== 0 || tv_seen !== 0) begin
            failures++;
            $display("FAIL len0_quiet got=re%0d/tv%0d want=0/0",
                     re_seen, tv_seen);
        end
    endtask

    task automatic test_restart();
        push(8'hD0);
        push(8'hD1);
        restart_at = 1;
        start = 1'b1; len = 10'd2;
        run(30);
        restart_at = -1;
        checks++;
        if (nbeats !== 2 || ndone !== 1 || re_seen !== 2) begin
            failures++;
            $display("FAIL restart_count got=%0d/%0d/%0d want=2/1/2",
                     nbeats, ndone, re_seen);
        end
        checks++;
        if (bd[0] !== 8'hD0 || bd[1] !== 8'hD1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL restart_data got=%0h,%0h busy=%b want=d0,d1 busy=0",
                     bd[0], bd[1], busy);
        end
    endtask

    task automatic test_max_len();
        int errs;
        int lasts;
        for (int i = 0; i < 1023; i++) push(8'(i));
        start = 1'b1; len = 10'd1023;
        run(1100);
        errs = 0;
        lasts = 0;
        for (int i = 0; i < nbeats; i++) begin
            if (bd[i] !== 8'(i)) errs++;
            if (bl[i]) lasts++;
        end
        checks++;
        if (nbeats !== 1023 || ndone !== 1) begin
            failures++;
            $display("FAIL max_count got=%0d/%0d want=1023/1", nbeats, ndone);
        end
        checks++;
        if (errs !== 0 || lasts !== 1 || bl[1022] !== 1'b1) begin
            failures++;
            $display("FAIL max_data got=errs%0d lasts%0d want=0/1",
                     errs, lasts);
        end
    endtask

    task automatic test_reset_mid();
        int rst_done;
        push(8'hB0);
        push(8'hB1);
        start = 1'b1; len = 10'd5;
        run(6);
        checks++;
        if (nbeats !== 2 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rmid_pre got=%0d busy=%b want=2 busy=1",
                     nbeats, busy);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, tvalid, tlast, fifo_re} !== 5'b0 || tdata !== 8'h00)
        begin
            failures++;
            $display("FAIL rmid_async got=%b/%0h want=00000/0",
                     {busy, done, tvalid, tlast, fifo_re}, tdata);
        end
        push(8'hB2);
        push(8'hB3);
        push(8'hB4);
        rst_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) rst_done++;
        end
        checks++;
        if (rst_done !== 0 || (wr_ptr - rd_ptr) !== 12'd3) begin
            failures++;
            $display("FAIL rmid_hold got=done%0d fifo%0d want=0/3",
                     rst_done, wr_ptr - rd_ptr);
        end
        rst = 1'b0;
        start = 1'b1; len = 10'd3;
        run(20);
        checks++;
        if (nbeats !== 3 || ndone !== 1 || bc[0] !== 1) begin
            failures++;
            $display("FAIL rmid_restart got=%0d/%0d first@%0d want=3/1 first@1",
                     nbeats, ndone, bc[0]);
        end
        checks++;
        if (bd[0] !== 8'hB2 || bd[1] !== 8'hB3 || bd[2] !== 8'hB4 ||
            bl[2] !== 1'b1) begin
            failures++;
            $display("FAIL rmid_data got=%0h,%0h,%0h/%b want=b2,b3,b4/1",
                     bd[0], bd[1], bd[2], bl[2]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_gap();
        test_len_zero();
        test_restart();
        test_max_len();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
